// File: rtl/ptw_mem_arbiter.sv
`default_nettype none
// ============================================================================
// ptw_mem_arbiter : arbitrates IF/LS page-table-walk reads onto one memory port
// Revision 1.0
// ============================================================================
module ptw_mem_arbiter #(
  parameter int ARB_MODE = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_rvalid_o,
  input  logic        ls_req_i,
  input  logic [31:0] ls_addr_i,
  output logic [31:0] ls_rdata_o,
  output logic        ls_rvalid_o,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_rvalid_i,
  input  logic        mmu_flush_i,
  output logic        busy_o,
  output logic        owner_ls_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] addr_q;
  logic        last_ls_q;
  logic        discard_q;
  logic        any_req;
  logic        grant_ls;

  assign any_req = if_req_i | ls_req_i;
  // Ties go to LS in fixed mode, otherwise to whichever side was not served last.
  assign grant_ls = ls_req_i & (~if_req_i | (ARB_MODE == 1) | ~last_ls_q);

  assign mem_req_valid_o = (state_q == ST_REQ);
  assign mem_addr_o      = addr_q;
  assign busy_o          = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (any_req)         state_d = ST_REQ;
      ST_REQ:  if (mem_req_ready_i) state_d = ST_WAIT;
      ST_WAIT: if (mem_rvalid_i)    state_d = ST_RESP;
      ST_RESP:                      state_d = ST_IDLE;
      default:                      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= 32'd0;
      owner_ls_o  <= 1'b0;
      last_ls_q   <= 1'b1;
      discard_q   <= 1'b0;
      if_rdata_o  <= 32'd0;
      ls_rdata_o  <= 32'd0;
      if_rvalid_o <= 1'b0;
      ls_rvalid_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      if_rvalid_o <= 1'b0;
      ls_rvalid_o <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            addr_q     <= grant_ls ? ls_addr_i : if_addr_i;
            owner_ls_o <= grant_ls;
          end
        end
        ST_REQ: begin
          if (mmu_flush_i) discard_q <= 1'b1;
        end
        ST_WAIT: begin
          if (mmu_flush_i) discard_q <= 1'b1;
          if (mem_rvalid_i) begin
            last_ls_q <= owner_ls_o;
            // A flush landing with the data discards this response too.
            if (!discard_q && !mmu_flush_i) begin
              if (owner_ls_o) begin
                ls_rdata_o  <= mem_rdata_i;
                ls_rvalid_o <= 1'b1;
              end else begin
                if_rdata_o  <= mem_rdata_i;
                if_rvalid_o <= 1'b1;
              end
            end
          end
        end
        ST_RESP: begin
          discard_q <= 1'b0;
        end
        default: begin
          discard_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
